// File: rtl/rfblackwidow_dcache_wrarb.sv
// Data-cache write-port arbiter.
// Three sources share one registered dcache write port: line-fill beats,
// page-table-walker updates and store hits. A fill burst locks the port to
// fills until its last beat. A saturating wait counter lifts a starved store
// above ptw and above the start of a new fill. Every write appears one cycle
// after its request is sampled, together with a one-cycle ack to the source.
module rfblackwidow_dcache_wrarb #(
    parameter int AWID   = 32,
    parameter int DWID   = 128,
    parameter int STARVE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inv,
    input  logic                fill_req,
    input  logic                fill_last,
    input  logic [AWID-1:0]     fill_adr,
    input  logic [DWID-1:0]     fill_dat,
    input  logic                st_req,
    input  logic [AWID-1:0]     st_adr,
    input  logic [DWID-1:0]     st_dat,
    input  logic [DWID/8-1:0]   st_sel,
    input  logic                ptw_req,
    input  logic [AWID-1:0]     ptw_adr,
    input  logic [DWID-1:0]     ptw_dat,
    input  logic [DWID/8-1:0]   ptw_sel,
    output logic                fill_ack,
    output logic                st_ack,
    output logic                ptw_ack,
    output logic                dc_wr,
    output logic [AWID-1:0]     dc_adr,
    output logic [DWID-1:0]     dc_dat,
    output logic [DWID/8-1:0]   dc_sel,
    output logic [1:0]          gnt,
    output logic                locked
);

    localparam int SWID = DWID / 8;
    localparam int CW   = $clog2(STARVE) + 1;

    localparam logic [CW-1:0] STARVE_C = CW'(STARVE);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_FILL = 2'd1;
    localparam logic [1:0] G_PTW  = 2'd2;
    localparam logic [1:0] G_ST   = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [AWID-1:0]   adr_q, adr_d;
    logic [DWID-1:0]   dat_q, dat_d;
    logic [SWID-1:0]   sel_q, sel_d;

    logic              fill_ok;
    logic              ptw_ok;
    logic              st_ok;
    logic              starve;

    // Select one source, derive next FSM state, wait counter and write payload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = G_NONE;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;

        // A source whose ack is on the outputs this cycle is not eligible,
        // so a request held into its ack cycle is never written twice.
        fill_ok = fill_req && (gnt_q != G_FILL);
        ptw_ok  = ptw_req && !inv && (state_q == S_IDLE) && (gnt_q != G_PTW);
        st_ok   = st_req  && !inv && (state_q == S_IDLE) && (gnt_q != G_ST);
        starve  = (cnt_q >= STARVE_C);

        // In FILL the ptw/store terms are already masked above, so only
        // fill beats can win there.
        if (starve && st_ok) begin
            gnt_d = G_ST;
        end else if (fill_ok) begin
            gnt_d = G_FILL;
        end else if (ptw_ok) begin
            gnt_d = G_PTW;
        end else if (st_ok) begin
            gnt_d = G_ST;
        end

        case (gnt_d)
            G_FILL: begin
                adr_d   = fill_adr;
                dat_d   = fill_dat;
                sel_d   = {SWID{1'b1}};
                state_d = fill_last ? S_IDLE : S_FILL;
            end
            G_PTW: begin
                adr_d = ptw_adr;
                dat_d = ptw_dat;
                sel_d = ptw_sel;
            end
            G_ST: begin
                adr_d = st_adr;
                dat_d = st_dat;
                sel_d = st_sel;
            end
            default: begin
            end
        endcase

        // Count cycles a store has been waiting; saturate instead of wrapping.
        if (!st_req || (gnt_d == G_ST)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Register FSM state, wait counter and the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gnt_q   <= G_NONE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    // Acks and the write strobe decode from the registered grant, so at most
    // one ack is ever high and dc_wr is exactly their OR.
    assign fill_ack = (gnt_q == G_FILL);
    assign ptw_ack  = (gnt_q == G_PTW);
    assign st_ack   = (gnt_q == G_ST);
    assign dc_wr    = (gnt_q != G_NONE);
    assign gnt      = gnt_q;
    assign dc_adr   = adr_q;
    assign dc_dat   = dat_q;
    assign dc_sel   = sel_q;
    assign locked   = (state_q == S_FILL);

endmodule
